board_clock_stimulus: RTL and testbench
=======================================

Name: board_clock_stimulus

Overview:
- Stimulus side of the board clock checkout. Runs on sysclk only.
- Generates the millisecond window strobe (sysclk_millice) that the clock counter consumes.
- Generates a programmable loopback test clock (testclk_out) that can be routed to a counted clock input on the bench or board.
- Reports the ideal per-window edge count for the active setting, so software or a VIO can compare it against the measured count.

Parameters:
- TICK_PERIOD, 100000, sysclk cycles per measurement window (1 ms at 100 MHz); legal range 64 to 2^32-1.
- DIV_WIDTH, 16, width of the half-period setting; legal range 1 to 31.

Ports:
- sysclk  in  1  system clock; all logic on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- div_half  in  DIV_WIDTH  requested testclk half-period in sysclk cycles; 0 = stopped.
- div_load  in  1  one-cycle request to stage div_half.
- div_busy  out  1  a staged setting is waiting for the next window boundary.
- sysclk_millice  out  1  one-cycle window strobe.
- testclk_out  out  1  generated test clock, registered.
- expected_count  out  32  ideal rising edges of testclk_out per window for the active setting.
- window_valid  out  1  at least one full window has completed with the active setting, and expected_count is final.

Behaviour:
- Reset values:
  - All outputs 0; tick counter 0.
  - Active half-period 0 (clock stopped); shadow 0; divider idle.
- Tick counter:
  - Counts 0..TICK_PERIOD-1 and wraps.
  - sysclk_millice is registered high for exactly one cycle when the counter equals TICK_PERIOD-1.
  - First strobe occurs TICK_PERIOD cycles after rst deasserts.
- Load handshake:
  - div_load=1 copies div_half into shadow and sets div_busy on the next edge.
  - div_load while div_busy: shadow is overwritten (last request wins); div_busy stays 1.
  - The shadow is applied in the cycle after sysclk_millice; div_busy clears in that same cycle.
  - div_load in the same cycle as sysclk_millice with div_busy=0 is captured, but applied at the following strobe, not the current one.
  - div_load in the same cycle as the strobe while div_busy=1: the new value replaces shadow and is applied now (last wins).
- Apply event:
  - Active half-period := shadow.
  - testclk_out := 0; half counter := 0.
  - window_valid := 0; divider starts.
  - Phase is therefore aligned to the window start.
- Clock generation:
  - Active value N=0: testclk_out held 0, half counter held 0.
  - N>0: the half counter counts 0..N-1; testclk_out toggles when the counter reaches N-1 and the counter wraps.
  - Result: period 2N cycles with 50% duty.
- Expected count:
  - expected_count = floor(TICK_PERIOD / (2N)), and 0 when N=0.
  - Computed by a serial restoring divider, one quotient bit per cycle: 32 cycles plus 1 cycle to latch.
  - Division by 2N is done with a 33-bit divisor, so no overflow occurs.
  - expected_count holds its old value while dividing and updates when the divider finishes.
  - N=0 bypasses the divider: expected_count is set to 0 the cycle after apply.
- Divider FSM states:
  - IDLE → DIV on apply with N>0.
  - DIV, 32 iterations → DONE.
  - DONE latches the result → IDLE.
- window_valid:
  - Set by the first sysclk_millice after apply when the divider is IDLE; remains 1 until the next apply.
  - TICK_PERIOD ≥ 64 guarantees the divider finishes before that strobe.
- Reset mid-operation: rst at any time aborts the divider, drops any pending shadow, stops the clock, and restores all reset values.
- Widths:
  - Tick counter is 32 bits.
  - Half counter is DIV_WIDTH bits.
  - The divider operates on unsigned 32-bit dividend and 33-bit divisor.

Decomposition:
- Shared package board_clock_pkg holds:
  - the tick counter width constant (32);
  - the divider state typedef {IDLE, DIV, DONE};
  - the default TICK_PERIOD.
- The divider is a natural sub-module: serial_udiv32, a start/busy/done serial unsigned divider that can be reused for other rate-check blocks.
- The top level holds tick counter, load handshake, and clock generator.

Test Plan (TICK_PERIOD=100 for sim):
- Reset: rst held 5 cycles then released → all outputs 0 and testclk_out static; first sysclk_millice exactly 100 cycles after release, then every 100 cycles.
- Basic setting: div_load with div_half=3 mid-window → div_busy=1 until the strobe; from the cycle after the strobe, testclk_out has period 6; expected_count=16 within 34 cycles; window_valid=1 at the next strobe.
- Last-wins: div_load values 1 then 7 within the same window → only 7 is applied (period 14, expected_count=7); div_half=1 alone → expected_count=50.
- Slow clock: div_half=60 → period 120, expected_count=0; div_half=0 → testclk_out stays 0 and expected_count=0.
- Strobe coincidence: div_load with div_busy=0 asserted in the strobe cycle → applied at the next strobe, 100 cycles later. Same with div_busy=1 → the new value is applied immediately.
- Reset mid-divide: rst asserted 10 cycles after an apply → divider idle, testclk_out=0, expected_count=0, div_busy=0, window_valid=0.

Source files
------------

// File: rtl/board_clock_pkg.sv
// Shared constants and types for the board clock checkout stimulus block.
package board_clock_pkg;

    localparam int TICK_WIDTH = 32;
    localparam int unsigned DEFAULT_TICK_PERIOD = 100000;

    typedef enum logic [1:0] {
        IDLE,
        DIV,
        DONE
    } div_state_t;

endpackage

// File: rtl/serial_udiv32.sv
// Serial restoring unsigned divider: 32-bit dividend, 33-bit divisor,
// one quotient bit per cycle, start/busy/done handshake.
//
// state | meaning
// IDLE  | waiting for start, operands not captured
// DIV   | 32 shift/subtract iterations in progress
// DONE  | quotient final for one cycle, then back to IDLE
module serial_udiv32
    import board_clock_pkg::*;
(
    input  logic                  sysclk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [TICK_WIDTH-1:0] dividend,
    input  logic [TICK_WIDTH:0]   divisor,
    output logic                  busy,
    output logic                  done,
    output logic [TICK_WIDTH-1:0] quotient
);

    div_state_t state, state_nxt;

    logic [4:0]            iter_cnt;
    logic [TICK_WIDTH:0]   rem;
    logic [TICK_WIDTH:0]   dvs;
    logic [TICK_WIDTH-1:0] quot;
    logic [TICK_WIDTH+1:0] shifted;
    logic [TICK_WIDTH:0]   sub;
    logic                  ge;

    // Remainder stays below the divisor, so the difference always fits in 33 bits.
    assign shifted  = {rem, quot[TICK_WIDTH-1]};
    assign ge       = (shifted >= {1'b0, dvs});
    assign sub      = shifted[TICK_WIDTH:0] - dvs;
    assign quotient = quot;

    always_ff @(posedge sysclk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_nxt = DIV;
            end
            DIV: begin
                busy = 1'b1;
                if (iter_cnt == 5'd31) state_nxt = DONE;
            end
            DONE: begin
                busy      = 1'b1;
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge sysclk or posedge rst) begin
        if (rst) begin
            iter_cnt <= '0;
            rem      <= '0;
            dvs      <= '0;
            quot     <= '0;
        end else if (state == IDLE && start) begin
            iter_cnt <= '0;
            rem      <= '0;
            dvs      <= divisor;
            quot     <= dividend;
        end else if (state == DIV) begin
            iter_cnt <= iter_cnt + 5'd1;
            rem      <= ge ? sub : shifted[TICK_WIDTH:0];
            quot     <= {quot[TICK_WIDTH-2:0], ge};
        end
    end

endmodule

// File: rtl/board_clock_stimulus.sv
// Window strobe, programmable loopback test clock and ideal per-window
// edge count for the board clock checkout.
module board_clock_stimulus
    import board_clock_pkg::*;
#(
    parameter int unsigned TICK_PERIOD = DEFAULT_TICK_PERIOD,
    parameter int          DIV_WIDTH   = 16
) (
    input  logic                  sysclk,
    input  logic                  rst,
    input  logic [DIV_WIDTH-1:0]  div_half,
    input  logic                  div_load,
    output logic                  div_busy,
    output logic                  sysclk_millice,
    output logic                  testclk_out,
    output logic [TICK_WIDTH-1:0] expected_count,
    output logic                  window_valid
);

    localparam logic [TICK_WIDTH-1:0] TICK_LAST = TICK_WIDTH'(TICK_PERIOD - 1);
    localparam logic [TICK_WIDTH-1:0] TICK_DIVIDEND = TICK_WIDTH'(TICK_PERIOD);
    localparam logic [TICK_WIDTH-1:0] TICK_ONE = TICK_WIDTH'(1);
    localparam logic [DIV_WIDTH-1:0]  DIV_ONE = DIV_WIDTH'(1);

    logic [TICK_WIDTH-1:0] tick_cnt;
    logic [DIV_WIDTH-1:0]  shadow;
    logic [DIV_WIDTH-1:0]  active;
    logic [DIV_WIDTH-1:0]  half_cnt;
    logic [DIV_WIDTH-1:0]  apply_val;
    logic [TICK_WIDTH:0]   divisor;
    logic                  apply;
    logic                  div_start;
    logic                  udiv_busy;
    logic                  udiv_done;
    logic [TICK_WIDTH-1:0] udiv_quot;

    // A request arriving on the apply edge itself wins over the staged value.
    assign apply     = sysclk_millice && div_busy;
    assign apply_val = div_load ? div_half : shadow;
    assign div_start = apply && (apply_val != '0);
    assign divisor   = {{(TICK_WIDTH - DIV_WIDTH){1'b0}}, apply_val, 1'b0};

    always_ff @(posedge sysclk or posedge rst) begin
        if (rst) begin
            tick_cnt       <= '0;
            sysclk_millice <= 1'b0;
        end else begin
            sysclk_millice <= (tick_cnt == TICK_LAST);
            tick_cnt       <= (tick_cnt == TICK_LAST) ? '0 : tick_cnt + TICK_ONE;
        end
    end

    always_ff @(posedge sysclk or posedge rst) begin
        if (rst) begin
            shadow   <= '0;
            div_busy <= 1'b0;
        end else if (apply) begin
            shadow   <= apply_val;
            div_busy <= 1'b0;
        end else if (div_load) begin
            shadow   <= div_half;
            div_busy <= 1'b1;
        end
    end

    always_ff @(posedge sysclk or posedge rst) begin
        if (rst) begin
            active      <= '0;
            half_cnt    <= '0;
            testclk_out <= 1'b0;
        end else if (apply) begin
            active      <= apply_val;
            half_cnt    <= '0;
            testclk_out <= 1'b0;
        end else if (active != '0) begin
            if (half_cnt == active - DIV_ONE) begin
                half_cnt    <= '0;
                testclk_out <= ~testclk_out;
            end else begin
                half_cnt <= half_cnt + DIV_ONE;
            end
        end
    end

    always_ff @(posedge sysclk or posedge rst) begin
        if (rst) begin
            expected_count <= '0;
            window_valid   <= 1'b0;
        end else begin
            if (udiv_done) begin
                expected_count <= udiv_quot;
            end else if (!udiv_busy && active == '0) begin
                expected_count <= '0;
            end
            if (apply) begin
                window_valid <= 1'b0;
            end else if (sysclk_millice && !udiv_busy) begin
                window_valid <= 1'b1;
            end
        end
    end

    serial_udiv32 u_div (
        .sysclk   (sysclk),
        .rst      (rst),
        .start    (div_start),
        .dividend (TICK_DIVIDEND),
        .divisor  (divisor),
        .busy     (udiv_busy),
        .done     (udiv_done),
        .quotient (udiv_quot)
    );

endmodule

// File: tb/tb_board_clock_stimulus.sv
// Self-checking bench for board_clock_stimulus with a window-level reference model.
module tb_board_clock_stimulus;

    localparam int unsigned TP = 100;
    localparam int          DW = 16;

    logic          sysclk = 1'b0;
    logic          rst = 1'b1;
    logic [DW-1:0] div_half = '0;
    logic          div_load = 1'b0;
    logic          div_busy;
    logic          sysclk_millice;
    logic          testclk_out;
    logic [31:0]   expected_count;
    logic          window_valid;

    int tests = 0;
    int fails = 0;

    // Reference model: edges since reset release plus the last apply event.
    int unsigned cyc;
    bit          m_busy;
    bit          m_applied;
    int unsigned m_shadow, m_n, m_apply, m_exp_old, m_exp_new, m_ready;

    board_clock_stimulus #(.TICK_PERIOD(TP), .DIV_WIDTH(DW)) dut (
        .sysclk         (sysclk),
        .rst            (rst),
        .div_half       (div_half),
        .div_load       (div_load),
        .div_busy       (div_busy),
        .sysclk_millice (sysclk_millice),
        .testclk_out    (testclk_out),
        .expected_count (expected_count),
        .window_valid   (window_valid)
    );

    always #5 sysclk = ~sysclk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        tests++;
        assert (obs === exp_v) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d (cycle %0d)", tag, obs, exp_v, cyc);
        end
    endtask

    function automatic bit m_strobe(input int unsigned c);
        return (c > 0) && (c % TP == 0);
    endfunction

    function automatic int unsigned m_expected(input int unsigned c);
        return (c >= m_ready) ? m_exp_new : m_exp_old;
    endfunction

    function automatic bit m_testclk();
        if (m_n == 0) return 1'b0;
        return (((cyc - m_apply) / m_n) % 2) != 0;
    endfunction

    task automatic model_reset();
        cyc = 0; m_busy = 0; m_applied = 0; m_shadow = 0; m_n = 0;
        m_apply = 0; m_exp_old = 0; m_exp_new = 0; m_ready = 0;
    endtask

    task automatic check_all();
        chk("millice", sysclk_millice, m_strobe(cyc));
        chk("div_busy", div_busy, m_busy);
        chk("testclk", testclk_out, m_testclk());
        chk("expected_count", expected_count, m_expected(cyc));
        if (m_applied) chk("window_valid", window_valid, (cyc >= m_apply + TP));
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_millice"}, sysclk_millice, 0);
        chk({tag, "_busy"}, div_busy, 0);
        chk({tag, "_testclk"}, testclk_out, 0);
        chk({tag, "_count"}, expected_count, 0);
        chk({tag, "_valid"}, window_valid, 0);
        chk({tag, "_divider"}, dut.u_div.busy, 0);
    endtask

    task automatic step();
        bit            strobe_prev, ld;
        logic [DW-1:0] hv;
        int unsigned   exp_before, val;
        strobe_prev = m_strobe(cyc);
        ld = div_load;
        hv = div_half;
        @(posedge sysclk);
        #1;
        exp_before = m_expected(cyc);
        cyc++;
        if (strobe_prev && m_busy) begin
            val       = int'(hv);
            if (!ld) val = m_shadow;
            m_exp_old = exp_before;
            m_n       = val;
            m_apply   = cyc;
            m_busy    = 0;
            m_applied = 1;
            m_exp_new = (val == 0) ? 0 : TP / (2 * val);
            m_ready   = (val == 0) ? cyc + 1 : cyc + 33;
        end else if (ld) begin
            m_shadow = int'(hv);
            m_busy   = 1;
        end
        check_all();
    endtask

    task automatic load(input int unsigned v);
        div_half = DW'(v);
        div_load = 1'b1;
        step();
        div_load = 1'b0;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic goto_offset(input int unsigned off);
        for (int i = 0; i < int'(TP) + 1; i++) begin
            step();
            if (cyc % TP == off) break;
        end
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b1;
        div_load = 1'b0;
        #1;
        check_reset_values(tag);
        repeat (5) @(posedge sysclk);
        #1;
        check_reset_values(tag);
        rst = 1'b0;
        model_reset();
    endtask

    initial begin
        model_reset();
        do_reset("reset");
        run(2 * TP + 10);

        goto_offset(50);
        load(3);
        run(2 * TP);
        chk("n3_count", expected_count, 16);
        chk("n3_valid", window_valid, 1);

        goto_offset(20);
        load(1);
        run(15);
        load(7);
        run(2 * TP);
        chk("last_wins_count", expected_count, 7);

        goto_offset(30);
        load(1);
        run(2 * TP);
        chk("n1_count", expected_count, 50);

        goto_offset(45);
        load(60);
        run(2 * TP);
        chk("n60_count", expected_count, 0);

        goto_offset(45);
        load(0);
        run(2 * TP);
        chk("n0_count", expected_count, 0);
        chk("n0_testclk", testclk_out, 0);

        // Load in the strobe cycle while idle: deferred by a full window.
        goto_offset(0);
        load(5);
        run(2 * TP + 5);
        chk("defer_count", expected_count, 10);

        // Load in the strobe cycle while a value is staged: applied at once.
        goto_offset(40);
        load(9);
        goto_offset(0);
        load(4);
        run(TP);
        chk("coincide_count", expected_count, 12);

        for (int k = 0; k < 8; k++) begin
            goto_offset($urandom_range(0, TP - 1));
            load($urandom_range(0, 80));
            if ($urandom_range(0, 2) == 0) begin
                run($urandom_range(1, 20));
                load($urandom_range(1, 80));
            end
            run($urandom_range(TP, 2 * TP));
        end

        goto_offset(50);
        load(2);
        goto_offset(1);
        run(10);
        do_reset("mid_divide");
        run(TP + 20);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
